// File: rtl/seg_pkg.sv
// seg_pkg - shared definitions for the seven-segment scan path.
//
// Holds the active-low segment codes for hex digits 0..F (bit order {g,f,e,d,c,b,a}),
// the error cause encodings reported by the capture block, the capture frame state
// encoding, and a helper that converts a one-hot-low anode word to its digit index.
// The display driver's decoder uses the same segment constants, so both sides of the
// loopback agree on a single table.
package seg_pkg;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    localparam logic [1:0] ERR_SEG     = 2'd0;
    localparam logic [1:0] ERR_SEQ     = 2'd1;
    localparam logic [1:0] ERR_ANODE   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_e;

    // Index of the lowest zero bit; only meaningful for a one-hot-low word.
    function automatic logic [2:0] anode_digit(input logic [7:0] anode_n);
        logic [2:0] idx;
        idx = '0;
        for (int k = 7; k >= 0; k--) begin
            if (!anode_n[k]) idx = 3'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg_scan_capture_if.sv
// seg_scan_capture_if - bundle of the scan lines and capture results.
//
// Signals:
//   anode[7:0]      scan select, active-low, one-hot-low (driven by the display side)
//   cathode[6:0]    segments {g,f,e,d,c,b,a}, active-low (driven by the display side)
//   value[31:0]     last good captured frame
//   frame_valid     one-cycle pulse when value updates
//   err             one-cycle pulse when a frame is discarded
//   err_code[1:0]   cause of the last err
//   busy            high while a frame is being collected
//   err_count[15:0] saturating error counter, present only with SEG_CAPTURE_ERRCNT_EN
// Modports: master = display/scan side, slave = capture block.
interface seg_scan_capture_if;

    logic [7:0]  anode;
    logic [6:0]  cathode;
    logic [31:0] value;
    logic        frame_valid;
    logic        err;
    logic [1:0]  err_code;
    logic        busy;
`ifdef SEG_CAPTURE_ERRCNT_EN
    logic [15:0] err_count;

    modport master (output anode, cathode,
                    input  value, frame_valid, err, err_code, busy, err_count);
    modport slave  (input  anode, cathode,
                    output value, frame_valid, err, err_code, busy, err_count);
`else
    modport master (output anode, cathode,
                    input  value, frame_valid, err, err_code, busy);
    modport slave  (input  anode, cathode,
                    output value, frame_valid, err, err_code, busy);
`endif

endinterface

// File: rtl/seg_to_nibble.sv
// seg_to_nibble - combinational seven-segment to hex decoder.
//
// Ports:
//   cathode[6:0]  in   active-low segments {g,f,e,d,c,b,a}
//   nibble[3:0]   out  decoded hex value (0 when the code is not recognised)
//   code_ok       out  high when cathode matches one of the 16 hex patterns
module seg_to_nibble
    import seg_pkg::*;
(
    input  logic [6:0] cathode,
    output logic [3:0] nibble,
    output logic       code_ok
);

    always_comb begin
        nibble  = 4'h0;
        code_ok = 1'b1;
        case (cathode)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: code_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_capture.sv
// seg_scan_capture - receive side of the multiplexed 8-digit seven-segment scan.
//
// Samples the active-low anode/cathode lines through a 2-flop synchroniser, waits for
// STABLE_CYCLES identical samples before accepting a digit, decodes it and reassembles
// the 32-bit word shown on the display (digit k = nibble [4k+3:4k]).
//
// Ports:
//   clock   in  system clock
//   reset   in  asynchronous, active-high reset
//   bus     seg_scan_capture_if.slave: anode/cathode in; value, frame_valid, err,
//           err_code, busy (and err_count when enabled) out
// Parameters:
//   STABLE_CYCLES   consecutive identical samples required before a digit is accepted
//   TIMEOUT_CYCLES  max clocks between accepted digits inside a frame
// Build option:
//   SEG_CAPTURE_ERRCNT_EN  adds a saturating 16-bit error counter on bus.err_count
module seg_scan_capture
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic              clock,
    input  logic              reset,
    seg_scan_capture_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

    logic [7:0]       anode_s1_q, anode_s2_q, last_anode_q, samp_anode_q;
    logic [6:0]       cath_s1_q, cath_s2_q, last_cath_q, samp_cath_q;
    logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;
    logic             acc_q, acc_d, chg;

    state_e           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      word_q, word_d, value_q, value_d;
    logic             fv_q, fv_d, err_q, err_d;
    logic [1:0]       code_q, code_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    logic [3:0]       nibble;
    logic             code_ok, blank, onehot;
    logic [2:0]       digit;

    seg_to_nibble u_dec (
        .cathode (samp_cath_q),
        .nibble  (nibble),
        .code_ok (code_ok)
    );

    // Stability filter: counter saturates at CNT_MAX so a held pattern is accepted once.
    always_comb begin
        chg = {anode_s2_q, cath_s2_q} != {last_anode_q, last_cath_q};
        stab_cnt_d = stab_cnt_q;
        if (chg)                      stab_cnt_d = '0;
        else if (stab_cnt_q != CNT_MAX) stab_cnt_d = stab_cnt_q + 1'b1;
        acc_d = (stab_cnt_d == CNT_MAX) && (chg || stab_cnt_q != CNT_MAX);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            anode_s1_q   <= 8'hFF;
            anode_s2_q   <= 8'hFF;
            last_anode_q <= 8'hFF;
            samp_anode_q <= 8'hFF;
            cath_s1_q    <= 7'h7F;
            cath_s2_q    <= 7'h7F;
            last_cath_q  <= 7'h7F;
            samp_cath_q  <= 7'h7F;
            stab_cnt_q   <= '0;
            acc_q        <= 1'b0;
        end else begin
            anode_s1_q   <= bus.anode;
            anode_s2_q   <= anode_s1_q;
            cath_s1_q    <= bus.cathode;
            cath_s2_q    <= cath_s1_q;
            last_anode_q <= anode_s2_q;
            last_cath_q  <= cath_s2_q;
            stab_cnt_q   <= stab_cnt_d;
            acc_q        <= acc_d;
            if (acc_d) begin
                samp_anode_q <= anode_s2_q;
                samp_cath_q  <= cath_s2_q;
            end
        end
    end

    // Frame FSM and inter-digit timeout.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        value_d = value_q;
        fv_d    = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        tmo_d   = '0;
        blank   = (samp_anode_q == 8'hFF);
        onehot  = $onehot(~samp_anode_q);
        digit   = anode_digit(samp_anode_q);

        if (acc_q && blank) begin
            // Blank slot between digits: frame and timeout both carry on.
            if (state_q == COLLECT) tmo_d = tmo_q + 1'b1;
        end else if (acc_q && !onehot) begin
            err_d   = 1'b1;
            code_d  = ERR_ANODE;
            state_d = IDLE;
        end else if (acc_q) begin
            if (state_q == IDLE) begin
                if (digit == 3'd0 && code_ok) begin
                    word_d  = {28'h0, nibble};
                    idx_d   = 3'd1;
                    state_d = COLLECT;
                end
            end else if (digit != idx_q) begin
                err_d  = 1'b1;
                code_d = ERR_SEQ;
                if (digit == 3'd0 && code_ok) begin
                    word_d = {28'h0, nibble};
                    idx_d  = 3'd1;
                end else begin
                    state_d = IDLE;
                end
            end else if (!code_ok) begin
                err_d   = 1'b1;
                code_d  = ERR_SEG;
                state_d = IDLE;
            end else begin
                word_d[4*idx_q +: 4] = nibble;
                if (idx_q == 3'd7) begin
                    value_d = word_d;
                    fv_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
        end else if (state_q == COLLECT) begin
            tmo_d = tmo_q + 1'b1;
            if (tmo_d == TMO_MAX) begin
                err_d   = 1'b1;
                code_d  = ERR_TIMEOUT;
                state_d = IDLE;
                tmo_d   = '0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            word_q  <= '0;
            value_q <= '0;
            fv_q    <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_SEG;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            value_q <= value_d;
            fv_q    <= fv_d;
            err_q   <= err_d;
            code_q  <= code_d;
            tmo_q   <= tmo_d;
        end
    end

    assign bus.value       = value_q;
    assign bus.frame_valid = fv_q;
    assign bus.err         = err_q;
    assign bus.err_code    = code_q;
    assign bus.busy        = (state_q == COLLECT);

`ifdef SEG_CAPTURE_ERRCNT_EN
    logic [15:0] errcnt_q, errcnt_d;

    always_comb begin
        errcnt_d = errcnt_q;
        if (err_d && errcnt_q != 16'hFFFF) errcnt_d = errcnt_q + 16'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) errcnt_q <= '0;
        else       errcnt_q <= errcnt_d;
    end

    assign bus.err_count = errcnt_q;
`endif

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture - directed bench for seg_scan_capture.
//
// Drives scan patterns through the interface and compares the capture outputs with
// hand-computed values. TIMEOUT_CYCLES is shortened so the timeout case stays quick.
// With SEG_CAPTURE_ERRCNT_EN defined the error counter is checked as well.
module tb_seg_scan_capture;

    localparam int TMO = 300;

    logic clk = 1'b0;
    logic rst;

    seg_scan_capture_if sif();

    seg_scan_capture #(
        .STABLE_CYCLES  (4),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (sif)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int n_checks = 0;
    int n_fail   = 0;
    int fv_cnt   = 0;
    int err_cnt  = 0;
    logic [1:0] last_code = 2'd0;
    int f0, e0;

    always @(negedge clk) begin
        if (!rst) begin
            if (sif.frame_valid) fv_cnt <= fv_cnt + 1;
            if (sif.err) begin
                err_cnt   <= err_cnt + 1;
                last_code <= sif.err_code;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] a, input logic [6:0] c, input int n);
        sif.anode   = a;
        sif.cathode = c;
        repeat (n) @(negedge clk);
    endtask

    task automatic digit(input int k, input logic [6:0] c, input int n);
        logic [7:0] a;
        a = ~(8'h01 << k);
        drive(a, c, n);
    endtask

    task automatic scan(input logic [31:0] w, input int first, input int last, input bit blanks);
        for (int d = first; d <= last; d++) begin
            digit(d, seg_tab[w[4*d +: 4]], 10);
            if (blanks) drive(8'hFF, 7'h7F, 10);
        end
    endtask

    initial begin
        rst         = 1'b1;
        sif.anode   = 8'hFF;
        sif.cathode = 7'h7F;
        repeat (3) @(negedge clk);
        check("rst_value", sif.value, 32'h0);
        check("rst_fv", {31'h0, sif.frame_valid}, 32'h0);
        check("rst_err", {31'h0, sif.err}, 32'h0);
        check("rst_code", {30'h0, sif.err_code}, 32'h0);
        check("rst_busy", {31'h0, sif.busy}, 32'h0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // 1: clean frame
        f0 = fv_cnt; e0 = err_cnt;
        scan(32'h1234ABCD, 0, 7, 1'b0);
        repeat (4) @(negedge clk);
        check("t1_fv", fv_cnt - f0, 1);
        check("t1_value", sif.value, 32'h1234ABCD);
        check("t1_err", err_cnt - e0, 0);
        check("t1_busy", {31'h0, sif.busy}, 32'h0);

        // 2: sequence error 0,1,3 then a full frame
        e0 = err_cnt;
        digit(0, seg_tab[0], 10);
        digit(1, seg_tab[1], 10);
        digit(3, seg_tab[3], 10);
        repeat (2) @(negedge clk);
        check("t2_err", err_cnt - e0, 1);
        check("t2_code", {30'h0, last_code}, 32'd1);
        check("t2_busy", {31'h0, sif.busy}, 32'h0);
        f0 = fv_cnt;
        scan(32'hCAFE0012, 0, 7, 1'b0);
        repeat (4) @(negedge clk);
        check("t2_fv", fv_cnt - f0, 1);
        check("t2_value", sif.value, 32'hCAFE0012);

        // 3: bad segment code on digit 4
        e0 = err_cnt;
        scan(32'h89ABCDEF, 0, 3, 1'b0);
        digit(4, 7'h7F, 10);
        check("t3_err", err_cnt - e0, 1);
        check("t3_code", {30'h0, last_code}, 32'd0);
        check("t3_value", sif.value, 32'hCAFE0012);
        check("t3_busy", {31'h0, sif.busy}, 32'h0);

        // 4: bad anode, then a frame with blank gaps
        e0 = err_cnt;
        drive(8'b11110011, seg_tab[0], 10);
        check("t4_err", err_cnt - e0, 1);
        check("t4_code", {30'h0, last_code}, 32'd2);
        f0 = fv_cnt; e0 = err_cnt;
        scan(32'h0F1E2D3C, 0, 7, 1'b1);
        check("t4_fv", fv_cnt - f0, 1);
        check("t4_value", sif.value, 32'h0F1E2D3C);
        check("t4_noerr", err_cnt - e0, 0);

        // 5: one-clock cathode glitches are filtered, then timeout
        e0 = err_cnt;
        for (int d = 0; d < 4; d++) begin
            logic [31:0] w5;
            w5 = 32'h55556789;
            digit(d, seg_tab[w5[4*d +: 4]], 2);
            digit(d, 7'h7F, 1);
            digit(d, seg_tab[w5[4*d +: 4]], 10);
        end
        check("t5_noerr", err_cnt - e0, 0);
        check("t5_busy", {31'h0, sif.busy}, 32'h1);
        repeat (200) @(negedge clk);
        check("t5_early", err_cnt - e0, 0);
        repeat (150) @(negedge clk);
        check("t5_err", err_cnt - e0, 1);
        check("t5_code", {30'h0, last_code}, 32'd3);
        check("t5_busy_off", {31'h0, sif.busy}, 32'h0);

        // 6: reset mid-frame, then three errors
        scan(32'h13579BDF, 0, 4, 1'b0);
        digit(5, seg_tab[4'hB], 3);
        check("t6_busy", {31'h0, sif.busy}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_value", sif.value, 32'h0);
        check("t6_fv", {31'h0, sif.frame_valid}, 32'h0);
        check("t6_err", {31'h0, sif.err}, 32'h0);
        check("t6_code", {30'h0, sif.err_code}, 32'h0);
        check("t6_busy0", {31'h0, sif.busy}, 32'h0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        e0 = err_cnt;
        drive(8'b11110011, seg_tab[0], 10);
        drive(8'b11001111, seg_tab[0], 10);
        drive(8'b11110011, seg_tab[0], 10);
        repeat (2) @(negedge clk);
        check("t6_errs", err_cnt - e0, 3);
        check("t6_code2", {30'h0, last_code}, 32'd2);
        check("t6_value_kept", sif.value, 32'h0);
`ifdef SEG_CAPTURE_ERRCNT_EN
        check("t6_err_count", {16'h0, sif.err_count}, 32'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
